// File: rtl/lsu_pipe.sv
// Load/store stage between execute and writeback: one memory access in flight,
// with alignment fault detection, lane shifting and load extension.
module lsu_pipe #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                exe_to_mem_valid,
    output logic                                mem_to_exe_ready,
    input  logic                                exe_regW,
    input  logic [REG_ADDR_WIDTH-1:0]           exe_regAddr,
    input  logic [DATA_WIDTH-1:0]               exe_regData,
    input  logic [3:0]                          exe_memOp,
    input  logic [ADDR_WIDTH-1:0]               exe_memAddr,
    input  logic [DATA_WIDTH-1:0]               exe_memWdata,
    output logic                                mem_req_valid,
    input  logic                                mem_req_ready,
    output logic                                mem_req_wen,
    output logic [ADDR_WIDTH-1:0]               mem_req_addr,
    output logic [DATA_WIDTH-1:0]               mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0]             mem_req_wmask,
    input  logic                                mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]               mem_resp_rdata,
    output logic                                mem_to_wb_valid,
    input  logic                                wb_to_mem_ready,
    output logic [REG_ADDR_WIDTH+DATA_WIDTH+1:0] mem_to_wb_bus
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFS = $clog2(NB);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]               state;
    logic                     accept;
    logic                     direct;
    logic [OFS-1:0]           ofs;
    logic [1:0]               size_log;
    logic                     is_load;
    logic                     is_store;
    logic                     bad_op;
    logic                     misaligned;
    logic                     fault;
    logic [7:0]               size_mask;
    logic [NB-1:0]            wmask_n;
    logic [DATA_WIDTH-1:0]    wdata_n;
    logic [ADDR_WIDTH-1:0]    req_addr_n;

    logic                     r_regW;
    logic [REG_ADDR_WIDTH-1:0] r_regAddr;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [3:0]               r_op;
    logic [OFS-1:0]           r_ofs;
    logic                     r_store;
    logic                     r_fault;
    logic [ADDR_WIDTH-1:0]    r_req_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [NB-1:0]            r_wmask;

    logic [DATA_WIDTH-1:0]    rshift;
    logic [DATA_WIDTH-1:0]    load_res;

    assign mem_to_exe_ready = (state == IDLE) || ((state == OUT) && wb_to_mem_ready);
    assign accept           = exe_to_mem_valid && mem_to_exe_ready;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        bad_op   = 1'b0;
        size_log = 2'd0;
        case (exe_memOp)
            4'd0:        ;
            4'd1, 4'd5:  begin is_load = 1'b1; size_log = 2'd0; end
            4'd2, 4'd6:  begin is_load = 1'b1; size_log = 2'd1; end
            4'd3:        begin is_load = 1'b1; size_log = 2'd2; end
            4'd7:        begin is_load = 1'b1; size_log = 2'd2; bad_op = (DATA_WIDTH == 32); end
            4'd4:        begin is_load = 1'b1; size_log = 2'd3; bad_op = (DATA_WIDTH == 32); end
            4'd9:        begin is_store = 1'b1; size_log = 2'd0; end
            4'd10:       begin is_store = 1'b1; size_log = 2'd1; end
            4'd11:       begin is_store = 1'b1; size_log = 2'd2; end
            4'd12:       begin is_store = 1'b1; size_log = 2'd3; bad_op = (DATA_WIDTH == 32); end
            default:     bad_op = 1'b1;
        endcase

        case (size_log)
            2'd0:    begin misaligned = 1'b0;                size_mask = 8'h01; end
            2'd1:    begin misaligned = exe_memAddr[0];      size_mask = 8'h03; end
            2'd2:    begin misaligned = |exe_memAddr[1:0];   size_mask = 8'h0F; end
            default: begin misaligned = |exe_memAddr[2:0];   size_mask = 8'hFF; end
        endcase

        fault      = bad_op || ((is_load || is_store) && misaligned);
        direct     = (exe_memOp == 4'd0) || fault;
        ofs        = exe_memAddr[OFS-1:0];
        wmask_n    = (is_store && !fault) ? (size_mask[NB-1:0] << ofs) : '0;
        wdata_n    = exe_memWdata << {ofs, 3'b000};
        req_addr_n = {exe_memAddr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
    end

    // Width casts of signed slices give sign extension; unsigned slices zero-fill.
    always_comb begin
        rshift = mem_resp_rdata >> {r_ofs, 3'b000};
        case (r_op)
            4'd1:    load_res = DATA_WIDTH'($signed(rshift[7:0]));
            4'd2:    load_res = DATA_WIDTH'($signed(rshift[15:0]));
            4'd3:    load_res = DATA_WIDTH'($signed(rshift[31:0]));
            4'd5:    load_res = DATA_WIDTH'(rshift[7:0]);
            4'd6:    load_res = DATA_WIDTH'(rshift[15:0]);
            4'd7:    load_res = DATA_WIDTH'(rshift[31:0]);
            default: load_res = rshift;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            r_regW <= 1'b0;
        end else begin
            if (accept) begin
                r_regW <= exe_regW;
                state  <= direct ? OUT : REQ;
            end else begin
                case (state)
                    REQ:     if (mem_req_ready)   state <= RESP;
                    RESP:    if (mem_resp_valid)  state <= OUT;
                    OUT:     if (wb_to_mem_ready) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            r_op       <= exe_memOp;
            r_ofs      <= ofs;
            r_store    <= is_store;
            r_fault    <= fault;
            r_regAddr  <= exe_regAddr;
            r_data     <= (exe_memOp == 4'd0) ? exe_regData : '0;
            r_req_addr <= req_addr_n;
            r_wdata    <= wdata_n;
            r_wmask    <= wmask_n;
        end else if ((state == RESP) && mem_resp_valid && !r_store) begin
            r_data <= load_res;
        end
    end

    assign mem_req_valid   = (state == REQ);
    assign mem_req_wen     = r_store;
    assign mem_req_addr    = r_req_addr;
    assign mem_req_wdata   = r_wdata;
    assign mem_req_wmask   = r_wmask;
    assign mem_to_wb_valid = (state == OUT);
    assign mem_to_wb_bus   = {r_regW & ~r_fault & ~r_store, r_regAddr, r_data, r_fault};

endmodule

// File: tb/tb_lsu_pipe.sv
// Scoreboard bench for lsu_pipe: directed ops push expected request/writeback
// values; a monitor pops and compares on each handshake.
module tb_lsu_pipe;
    localparam int RAW = 5;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NB  = DW / 8;
    localparam int BW  = RAW + DW + 2;
    localparam int QW  = 1 + AW + DW + NB;

    logic            clk;
    logic            rst;
    logic            exe_to_mem_valid;
    logic            mem_to_exe_ready;
    logic            exe_regW;
    logic [RAW-1:0]  exe_regAddr;
    logic [DW-1:0]   exe_regData;
    logic [3:0]      exe_memOp;
    logic [AW-1:0]   exe_memAddr;
    logic [DW-1:0]   exe_memWdata;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_wen;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_wdata;
    logic [NB-1:0]   mem_req_wmask;
    logic            mem_resp_valid;
    logic [DW-1:0]   mem_resp_rdata;
    logic            mem_to_wb_valid;
    logic            wb_to_mem_ready;
    logic [BW-1:0]   mem_to_wb_bus;

    lsu_pipe #(.REG_ADDR_WIDTH(RAW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .exe_to_mem_valid(exe_to_mem_valid), .mem_to_exe_ready(mem_to_exe_ready),
        .exe_regW(exe_regW), .exe_regAddr(exe_regAddr), .exe_regData(exe_regData),
        .exe_memOp(exe_memOp), .exe_memAddr(exe_memAddr), .exe_memWdata(exe_memWdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .mem_to_wb_valid(mem_to_wb_valid), .wb_to_mem_ready(wb_to_mem_ready),
        .mem_to_wb_bus(mem_to_wb_bus)
    );

    int total = 0;
    int bad   = 0;
    logic [BW-1:0] bus_q[$];
    logic [QW-1:0] req_q[$];
    logic [DW-1:0] next_rdata = '0;
    logic          pending = 1'b0;
    bit            resp_hold = 1'b0;
    time           acc_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout/unexpected event expected none", name);
    endtask

    // Zero-wait memory: a response follows one cycle after each request handshake.
    initial begin
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h5A5A5A5A;
        forever begin
            @(negedge clk);
            #1;
            if (!resp_hold) begin
                mem_resp_valid = pending;
                mem_resp_rdata = pending ? next_rdata : 32'h5A5A5A5A;
            end
            pending = mem_req_valid && mem_req_ready;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0) begin
                if (mem_req_valid && mem_req_ready) begin
                    if (req_q.size() == 0) fail_now("req_unexpected");
                    else check("req_fields", {mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask}, req_q.pop_front());
                end
                if (mem_to_wb_valid && wb_to_mem_ready) begin
                    if (bus_q.size() == 0) fail_now("wb_unexpected");
                    else check("wb_bus", mem_to_wb_bus, bus_q.pop_front());
                end
            end
        end
    end

    task automatic vec(input logic [3:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [DW-1:0] rdata, input logic [DW-1:0] regdata, input logic regw,
                       input logic [RAW-1:0] rd, input bit has_req, input logic [QW-1:0] req_e,
                       input bit has_bus, input logic [BW-1:0] bus_e);
        bit accepted = 1'b0;
        if (has_req) req_q.push_back(req_e);
        if (has_bus) bus_q.push_back(bus_e);
        exe_memOp        = op;
        exe_memAddr      = addr;
        exe_memWdata     = wdata;
        exe_regData      = regdata;
        exe_regW         = regw;
        exe_regAddr      = rd;
        exe_to_mem_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (mem_to_exe_ready) begin
                @(posedge clk);
                acc_t      = $time;
                next_rdata = rdata;
                accepted   = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) fail_now("accept_timeout");
        @(negedge clk);
        exe_to_mem_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 50 && (bus_q.size() != 0 || req_q.size() != 0); n++) @(negedge clk);
        if (bus_q.size() != 0 || req_q.size() != 0) begin
            fail_now("drain_timeout");
            bus_q.delete();
            req_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        time t1;
        rst = 1'b1;
        exe_to_mem_valid = 1'b0;
        exe_regW = 1'b0;
        exe_regAddr = '0;
        exe_regData = '0;
        exe_memOp = '0;
        exe_memAddr = '0;
        exe_memWdata = '0;
        mem_req_ready = 1'b1;
        wb_to_mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_wb_valid", mem_to_wb_valid, 1'b0);
        check("reset_req_valid", mem_req_valid, 1'b0);
        check("reset_exe_ready", mem_to_exe_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        vec(4'd0, 32'h0, 32'h0, 32'h0, 32'h1234, 1'b1, 5'd3, 0, '0, 1, {1'b1, 5'd3, 32'h00001234, 1'b0});
        check("op0_latency1", mem_to_wb_valid, 1'b1);
        wait_idle();

        vec(4'd1, 32'h1003, 32'h0, 32'h80FFFFFF, 32'h0, 1'b1, 5'd5,
            1, {1'b0, 32'h1000, 32'h0, 4'h0}, 1, {1'b1, 5'd5, 32'hFFFFFF80, 1'b0});
        check("lb_req_phase", {mem_req_valid, mem_to_wb_valid}, 2'b10);
        @(negedge clk);
        check("lb_resp_phase", mem_to_wb_valid, 1'b0);
        @(negedge clk);
        check("lb_latency3", mem_to_wb_valid, 1'b1);
        wait_idle();

        vec(4'd5, 32'h1003, 32'h0, 32'h80FFFFFF, 32'h0, 1'b1, 5'd6,
            1, {1'b0, 32'h1000, 32'h0, 4'h0}, 1, {1'b1, 5'd6, 32'h00000080, 1'b0});
        wait_idle();
        vec(4'd10, 32'h2002, 32'h0000BEEF, 32'hDEADBEEF, 32'h777, 1'b1, 5'd7,
            1, {1'b1, 32'h2000, 32'hBEEF0000, 4'hC}, 1, {1'b0, 5'd7, 32'h0, 1'b0});
        wait_idle();

        vec(4'd3, 32'h3001, 32'h0, 32'h0, 32'h0, 1'b1, 5'd8, 0, '0, 1, {1'b0, 5'd8, 32'h0, 1'b1});
        check("fault_latency1", {mem_to_wb_valid, mem_req_valid}, 2'b10);
        wait_idle();
        vec(4'd4, 32'h3000, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9, 0, '0, 1, {1'b0, 5'd9, 32'h0, 1'b1});
        wait_idle();

        vec(4'd2, 32'h1002, 32'h0, 32'h80010000, 32'h0, 1'b1, 5'd10,
            1, {1'b0, 32'h1000, 32'h0, 4'h0}, 1, {1'b1, 5'd10, 32'hFFFF8001, 1'b0});
        vec(4'd6, 32'h1002, 32'h0, 32'h80010000, 32'h0, 1'b1, 5'd10,
            1, {1'b0, 32'h1000, 32'h0, 4'h0}, 1, {1'b1, 5'd10, 32'h00008001, 1'b0});
        vec(4'd3, 32'h4000, 32'h0, 32'h89ABCDEF, 32'h0, 1'b1, 5'd11,
            1, {1'b0, 32'h4000, 32'h0, 4'h0}, 1, {1'b1, 5'd11, 32'h89ABCDEF, 1'b0});
        vec(4'd9, 32'h5001, 32'h000000A5, 32'h0, 32'h0, 1'b1, 5'd12,
            1, {1'b1, 32'h5000, 32'h0000A500, 4'h2}, 1, {1'b0, 5'd12, 32'h0, 1'b0});
        vec(4'd11, 32'h5004, 32'h11223344, 32'h0, 32'h0, 1'b1, 5'd12,
            1, {1'b1, 32'h5004, 32'h11223344, 4'hF}, 1, {1'b0, 5'd12, 32'h0, 1'b0});
        vec(4'd8, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd13, 0, '0, 1, {1'b0, 5'd13, 32'h0, 1'b1});
        vec(4'd13, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd14, 0, '0, 1, {1'b0, 5'd14, 32'h0, 1'b1});
        vec(4'd2, 32'h1001, 32'h0, 32'h0, 32'h0, 1'b1, 5'd15, 0, '0, 1, {1'b0, 5'd15, 32'h0, 1'b1});
        vec(4'd7, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd16, 0, '0, 1, {1'b0, 5'd16, 32'h0, 1'b1});
        vec(4'd0, 32'h0, 32'h0, 32'h0, 32'hABCD, 1'b0, 5'd2, 0, '0, 1, {1'b0, 5'd2, 32'h0000ABCD, 1'b0});
        wait_idle();

        // Memory stall then writeback stall.
        mem_req_ready = 1'b0;
        wb_to_mem_ready = 1'b0;
        vec(4'd3, 32'h6000, 32'h55, 32'hCAFEF00D, 32'h0, 1'b1, 5'd17,
            1, {1'b0, 32'h6000, 32'h55, 4'h0}, 1, {1'b1, 5'd17, 32'hCAFEF00D, 1'b0});
        for (int i = 0; i < 5; i++) begin
            check("stall_req_hold", {mem_req_valid, mem_to_exe_ready, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask},
                  {1'b1, 1'b0, 1'b0, 32'h6000, 32'h55, 4'h0});
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        for (int n = 0; n < 20 && !mem_to_wb_valid; n++) @(negedge clk);
        if (!mem_to_wb_valid) fail_now("stall_wb_timeout");
        for (int i = 0; i < 3; i++) begin
            check("stall_wb_hold", {mem_to_wb_valid, mem_to_exe_ready, mem_to_wb_bus},
                  {1'b1, 1'b0, 1'b1, 5'd17, 32'hCAFEF00D, 1'b0});
            @(negedge clk);
        end
        wb_to_mem_ready = 1'b1;
        wait_idle();

        // Reset while waiting for the response; the late response must be dropped.
        resp_hold = 1'b1;
        mem_resp_valid = 1'b0;
        vec(4'd3, 32'h7000, 32'h0, 32'h0, 32'h0, 1'b1, 5'd20, 1, {1'b0, 32'h7000, 32'h0, 4'h0}, 0, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset", {mem_req_valid, mem_to_wb_valid, mem_to_exe_ready}, 3'b001);
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h12345678;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_resp_ignored", {mem_to_wb_valid, mem_req_valid}, 2'b00);
            @(negedge clk);
        end
        resp_hold = 1'b0;

        vec(4'd0, 32'h0, 32'h0, 32'h0, 32'h101, 1'b1, 5'd21, 0, '0, 1, {1'b1, 5'd21, 32'h101, 1'b0});
        t1 = acc_t;
        vec(4'd0, 32'h0, 32'h0, 32'h0, 32'h102, 1'b1, 5'd22, 0, '0, 1, {1'b1, 5'd22, 32'h102, 1'b0});
        vec(4'd0, 32'h0, 32'h0, 32'h0, 32'h103, 1'b1, 5'd23, 0, '0, 1, {1'b1, 5'd23, 32'h103, 1'b0});
        vec(4'd0, 32'h0, 32'h0, 32'h0, 32'h104, 1'b1, 5'd24, 0, '0, 1, {1'b1, 5'd24, 32'h104, 1'b0});
        check("b2b_accept_spacing", 128'(acc_t - t1), 128'd30);
        check("b2b_last_valid", mem_to_wb_valid, 1'b1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_pipe.md
LSU_PIPE -- requirements
Module: lsu_pipe

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5, SHALL be the destination register index width.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL be the memory address width.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL be the datapath width, legal values 32 or 64; NB = DATA_WIDTH/8, OFS = log2(NB).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 Ports (name  dir  width  meaning) SHALL be:
- clk  in  1  clock
- rst  in  1  async active-high reset
- exe_to_mem_valid  in  1  upstream op valid
- mem_to_exe_ready  out  1  stage can accept op
- exe_regW  in  1  op writes a register
- exe_regAddr  in  REG_ADDR_WIDTH  destination register
- exe_regData  in  DATA_WIDTH  ALU result, used for non-memory ops
- exe_memOp  in  4  0 none; 1 lb, 2 lh, 3 lw, 4 ld, 5 lbu, 6 lhu, 7 lwu; 9 sb, 10 sh, 11 sw, 12 sd
- exe_memAddr  in  ADDR_WIDTH  byte address
- exe_memWdata  in  DATA_WIDTH  store data, LSB-aligned
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_wen  out  1  1 = store
- mem_req_addr  out  ADDR_WIDTH  address, low OFS bits forced to 0
- mem_req_wdata  out  DATA_WIDTH  lane-shifted store data
- mem_req_wmask  out  NB  byte enables, all 0 for loads
- mem_resp_valid  in  1  read data or write ack
- mem_resp_rdata  in  DATA_WIDTH  read data
- mem_to_wb_valid / wb_to_mem_ready  out / in  1  writeback handshake
- mem_to_wb_bus  out  REG_ADDR_WIDTH+DATA_WIDTH+2  {regW, regAddr, regData, fault}

Function
REQ-006 States SHALL be IDLE, REQ, RESP, OUT; mem_to_wb_valid = (state==OUT); mem_req_valid = (state==REQ).
REQ-007 mem_to_exe_ready SHALL be (state==IDLE) or (state==OUT and wb_to_mem_ready).
REQ-008 An op SHALL be accepted when exe_to_mem_valid and mem_to_exe_ready; all exe_* fields are latched that cycle.
REQ-009 Fault SHALL be raised when the address is not aligned to the access size, when op is 4/7/12 with DATA_WIDTH=32, or when op is 8, 13, 14 or 15.
REQ-010 An accepted op with memOp 0, or one that faults, SHALL go directly to OUT (latency 1 cycle); all others go to REQ.
REQ-011 In REQ, request fields SHALL be stable until mem_req_ready; on handshake the state goes to RESP.
REQ-012 In RESP, mem_resp_valid SHALL capture mem_resp_rdata and move to OUT; mem_resp_valid in any other state is ignored.
REQ-013 Store wmask SHALL be the size mask (1, 3, 0xF or 0xFF) shifted left by addr[OFS-1:0]; wdata is exe_memWdata shifted left by 8*addr[OFS-1:0].
REQ-014 Load result SHALL be rdata shifted right by 8*addr[OFS-1:0], then sign-extended (ops 1-4) or zero-extended (ops 5-7) to DATA_WIDTH.
REQ-015 bus regData SHALL be: the load result for loads, exe_regData for op 0, and 0 for stores and faults.
REQ-016 bus regW SHALL be latched regW AND NOT fault AND NOT store.
REQ-017 In OUT, wb_to_mem_ready without a new accept SHALL go to IDLE; with a same-cycle accept it goes to OUT or REQ per REQ-010 (back-to-back, no bubble).
REQ-018 Minimum memory-op latency accept-to-mem_to_wb_valid SHALL be 3 cycles (REQ, RESP, OUT) with zero-wait memory.

Reset
REQ-019 rst SHALL asynchronously force IDLE, so that mem_to_wb_valid=0, mem_req_valid=0 and the latched regW=0; datapath registers need no reset.
REQ-020 Reset in REQ or RESP SHALL abandon the access; a late mem_resp_valid after reset is ignored.

Verification
REQ-021 DATA_WIDTH=32, op 0, regData=0x1234, regW=1, wb ready -> bus {1, rd, 0x1234, 0} with valid one cycle after accept.
REQ-022 lb at addr 0x1003, rdata 0x80FFFFFF -> req addr 0x1000, wmask 0; regData 0xFFFFFF80. Same case with lbu -> 0x00000080.
REQ-023 sh at 0x2002, wdata 0x0000BEEF -> wmask 0xC, req wdata 0xBEEF0000, wen 1; bus regW=0.
REQ-024 lw at 0x3001 -> no mem_req_valid; fault=1, regW=0, valid after 1 cycle. ld with DATA_WIDTH=32 -> fault.
REQ-025 mem_req_ready held low 5 cycles, then wb_to_mem_ready low 3 cycles -> request fields and output bus stable throughout; mem_to_exe_ready low.
REQ-026 Assert rst during RESP, then pulse mem_resp_valid -> state IDLE, mem_to_wb_valid stays 0. Separately, back-to-back op 0 stream with wb ready -> one result per cycle.
